// File: rtl/bram_byte_fetch.sv
// BRAM port-B byte fetcher: polls fifo_ready, handshakes frame_ready, captures toggled data words.
// Optional WAIT_DATA watchdog enabled by defining BRAM_FETCH_TIMEOUT_EN.
`timescale 1ns/1ps
module bram_byte_fetch #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned LOW_HOLD     = 8,
    parameter int unsigned POLL_GAP     = 4,
    parameter int unsigned TIMEOUT_CYC  = 1024
) (
    input  logic        clk_100mhz,
    input  logic        rst_n,
    input  logic [8:0]  bram_doutb,
    output logic [1:0]  bram_addrb,
    output logic [8:0]  bram_dinb,
    output logic        bram_web,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        fifo_avail,
    output logic [15:0] byte_count,
    output logic        timeout_err
);

    localparam logic [2:0] S_SYNC     = 3'd0;
    localparam logic [2:0] S_SYNC_WR  = 3'd1;
    localparam logic [2:0] S_HOLD_LOW = 3'd2;
    localparam logic [2:0] S_POLL     = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_REQ      = 3'd5;
    localparam logic [2:0] S_WAIT     = 3'd6;
    localparam logic [2:0] S_RELEASE  = 3'd7;

    localparam int unsigned HOLD_LAST = (LOW_HOLD > 0) ? LOW_HOLD - 1 : 0;
    localparam int unsigned GAP_LAST  = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
    localparam int unsigned CNT_MAX0  = (READ_LATENCY > HOLD_LAST) ? READ_LATENCY : HOLD_LAST;
    localparam int unsigned CNT_MAX   = (CNT_MAX0 > GAP_LAST) ? CNT_MAX0 : GAP_LAST;
    localparam int unsigned CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last_tog;
    logic             rd_done;

    // One read occupies READ_LATENCY+1 cycles; doutb is sampled on the last one.
    assign rd_done = (cnt == CNT_W'(READ_LATENCY));

`ifdef BRAM_FETCH_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    logic [TMO_W-1:0] tmo;
`else
    assign timeout_err = (TIMEOUT_CYC == 0) & 1'b0;
`endif

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_SYNC;
            cnt        <= '0;
            bram_addrb <= 2'd2;
            bram_dinb  <= '0;
            bram_web   <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            fifo_avail <= 1'b0;
            byte_count <= '0;
            last_tog   <= 1'b0;
`ifdef BRAM_FETCH_TIMEOUT_EN
            tmo         <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            bram_web <= 1'b0;

            if (m_valid && m_ready) begin
                m_valid    <= 1'b0;
                byte_count <= byte_count + 16'd1;
            end

            case (state)
                S_SYNC: begin
                    if (rd_done) begin
                        last_tog   <= bram_doutb[0];
                        bram_addrb <= 2'd0;
                        bram_dinb  <= '0;
                        bram_web   <= 1'b1;
                        state      <= S_SYNC_WR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_SYNC_WR, S_RELEASE: begin
                    bram_addrb <= 2'd1;
                    bram_dinb  <= '0;
                    cnt        <= '0;
                    state      <= S_HOLD_LOW;
                end

                S_HOLD_LOW: begin
                    if (cnt == CNT_W'(HOLD_LAST)) begin
                        cnt   <= '0;
                        state <= S_POLL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_POLL: begin
                    if (rd_done) begin
                        fifo_avail <= bram_doutb[0];
                        cnt        <= '0;
                        // A request may only go out once the output slot is free or freeing now.
                        if (bram_doutb[0] && (!m_valid || m_ready)) begin
                            bram_addrb <= 2'd0;
                            bram_dinb  <= 9'd1;
                            bram_web   <= 1'b1;
                            state      <= S_REQ;
                        end else begin
                            state <= S_GAP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_GAP: begin
                    if (cnt == CNT_W'(GAP_LAST)) begin
                        cnt   <= '0;
                        state <= S_POLL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_REQ: begin
                    bram_addrb <= 2'd2;
                    bram_dinb  <= '0;
                    cnt        <= '0;
                    state      <= S_WAIT;
`ifdef BRAM_FETCH_TIMEOUT_EN
                    tmo <= '0;
`endif
                end

                S_WAIT: begin
`ifdef BRAM_FETCH_TIMEOUT_EN
                    tmo <= tmo + TMO_W'(1);
`endif
                    if (rd_done && (bram_doutb[0] != last_tog)) begin
                        m_data     <= bram_doutb[8:1];
                        m_valid    <= 1'b1;
                        last_tog   <= bram_doutb[0];
                        bram_addrb <= 2'd0;
                        bram_dinb  <= '0;
                        bram_web   <= 1'b1;
                        state      <= S_RELEASE;
                    end
`ifdef BRAM_FETCH_TIMEOUT_EN
                    else if (tmo == TMO_W'(TMO_LAST)) begin
                        timeout_err <= 1'b1;
                        bram_addrb  <= 2'd0;
                        bram_dinb   <= '0;
                        bram_web    <= 1'b1;
                        state       <= S_RELEASE;
                    end
`endif
                    else if (rd_done) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= S_SYNC;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_byte_fetch.sv
// Scoreboarded bench for bram_byte_fetch with a behavioural BRAM and 25 MHz mailbox writer.
`timescale 1ns/1ps
module tb_bram_byte_fetch;

    localparam int unsigned RL       = 2;
    localparam int unsigned LOW_HOLD = 8;

    logic        clk = 1'b0;
    logic        clk25 = 1'b0;
    logic        rst_n = 1'b1;
    logic [8:0]  doutb;
    logic [1:0]  addrb;
    logic [8:0]  dinb;
    logic        web;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        fifo_avail;
    logic [15:0] byte_count;
    logic        timeout_err;

    bram_byte_fetch #(
        .READ_LATENCY(RL),
        .LOW_HOLD(LOW_HOLD),
        .POLL_GAP(4),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .bram_doutb (doutb),
        .bram_addrb (addrb),
        .bram_dinb  (dinb),
        .bram_web   (web),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_avail (fifo_avail),
        .byte_count (byte_count),
        .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;
    initial begin
        #3;
        forever #20 clk25 = ~clk25;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural BRAM: addr0 = frame_ready (port B), addr1 = fifo_ready, addr2 = writer data word.
    logic       a0 = 1'b0;
    logic       fifo = 1'b0;
    logic [8:0] a2 = '0;
    logic [8:0] pipe [RL];

    function automatic logic [8:0] rd_word(input logic [1:0] a);
        case (a)
            2'd0:    return {8'b0, a0};
            2'd1:    return {8'b0, fifo};
            2'd2:    return a2;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (web && addrb == 2'd0) a0 <= dinb[0];
        pipe[0] <= rd_word(addrb);
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign doutb = pipe[RL-1];

    // Writer model: answers each sampled 0->1 edge of addr0 three ticks later.
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    bit         silent = 1'b0;
    bit         preset_req = 1'b0;
    logic [8:0] preset_val = '0;
    logic       a0_prev = 1'b0;
    int         wr_cnt = 0;

    always @(posedge clk25) begin
        logic [7:0] b;
        if (preset_req) begin
            a2 = preset_val;
            preset_req = 1'b0;
        end
        if (wr_cnt != 0) begin
            wr_cnt--;
            if (wr_cnt == 0) begin
                b = (tx_q.size() != 0) ? tx_q.pop_front() : 8'($urandom);
                a2 = {b, ~a2[0]};
                exp_q.push_back(b);
            end
        end
        if (a0 && !a0_prev && !silent) wr_cnt = 3;
        a0_prev = a0;
    end

    int ready_mode = 0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            m_ready = 1'b1;
        end else if (m_valid && !m_ready) begin
            stall_cnt++;
            if (stall_cnt >= 20) m_ready = 1'b1;
        end else begin
            m_ready = 1'b0;
            stall_cnt = 0;
        end
    end

    // Monitor: scoreboard pops plus protocol rule counters.
    logic [15:0] exp_count = '0;
    bit          cnt_pending = 1'b0;
    int          accepted = 0;
    int          req_seen = 0;
    int          since_low = 0;
    int          web_viol = 0, gate_viol = 0, hold_viol = 0, stall_viol = 0, deassert_viol = 0;
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_web = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [7:0]  exp_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_count   = '0;
            cnt_pending = 1'b0;
            prev_valid  = 1'b0;
            prev_ready  = 1'b0;
            prev_web    = 1'b0;
        end else begin
            if (cnt_pending) begin
                check("byte_count", byte_count, exp_count);
                cnt_pending = 1'b0;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'b0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("m_data", m_data, exp_b);
                end
                exp_count   = exp_count + 16'd1;
                accepted++;
                cnt_pending = 1'b1;
            end
            if (prev_valid && !prev_ready && m_valid && m_data !== prev_data) stall_viol++;
            if (prev_valid && prev_ready && m_valid) deassert_viol++;
            if (web && (addrb != 2'd0 || dinb[8:1] != 8'd0)) web_viol++;
            if (web && prev_web) web_viol++;
            since_low++;
            if (web && dinb[0]) begin
                if (m_valid) gate_viol++;
                if (since_low < LOW_HOLD) hold_viol++;
                req_seen++;
            end
            if (web && !dinb[0]) since_low = 0;
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
            prev_web   = web;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_accepts(input int target, input int budget, input string name);
        int c = 0;
        while (accepted < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check(name, accepted, target);
    endtask

    task automatic wait_req(input int target, input int budget, input string name);
        int c = 0;
        while (req_seen < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check(name, req_seen, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, spur, n, acc0, r0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_addrb", addrb, 2'd2);
        check("rst_dinb", dinb, 9'd0);
        check("rst_web", web, 1'b0);
        check("rst_m_data", m_data, 8'd0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_fifo_avail", fifo_avail, 1'b0);
        check("rst_byte_count", byte_count, 16'd0);
        check("rst_timeout_err", timeout_err, 1'b0);
        cycles(5);
        rst_n = 1'b1;

        // Idle: fifo_ready low.
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (i >= 50 && (addrb !== 2'd1 || web !== 1'b0)) bad++;
        end
        #1;
        check("t1_only_addr1_reads", bad, 0);
        check("t1_no_request", req_seen, 0);
        check("t1_addr0_low", a0, 1'b0);
        check("t1_m_valid", m_valid, 1'b0);
        check("t1_fifo_avail", fifo_avail, 1'b0);

        // Single byte.
        tx_q.push_back(8'hA5);
        fifo = 1'b1;
        wait_req(1, 200, "t2_request");
        check("t2_fifo_avail", fifo_avail, 1'b1);
        fifo = 1'b0;
        wait_accepts(1, 300, "t2_accept");
        cycles(3);
        check("t2_byte_count", byte_count, 16'd1);
        check("t2_addr0_released", a0, 1'b0);

        // Sixteen bytes with a stalled consumer.
        ready_mode = 1;
        for (int b = 1; b <= 16; b++) tx_q.push_back(8'(b));
        fifo = 1'b1;
        wait_accepts(17, 4000, "t3_accept16");
        fifo = 1'b0;
        cycles(200);
        ready_mode = 0;
        cycles(5);
        check("t3_drained", exp_q.size(), 0);
        check("t3_data_stable", stall_viol, 0);
        check("t3_req_gated", gate_viol, 0);

        // Resync after reset with the writer toggle already at 1.
        preset_val = 9'h1FF;
        preset_req = 1'b1;
        cycles(12);
        rst_n = 1'b0;
        cycles(5);
        exp_q.delete();
        rst_n = 1'b1;
        spur = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_valid) spur++;
        end
        #1;
        check("t4_no_spurious", spur, 0);
        acc0 = accepted;
        tx_q.push_back(8'h52);
        fifo = 1'b1;
        wait_accepts(acc0 + 1, 400, "t4_accept");
        fifo = 1'b0;
        cycles(50);

`ifdef BRAM_FETCH_TIMEOUT_EN
        silent = 1'b1;
        r0 = req_seen;
        fifo = 1'b1;
        wait_req(r0 + 1, 300, "t5_request");
        fifo = 1'b0;
        n = 0;
        while (!timeout_err && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_timeout_window", (n >= 60 && n <= 70), 1'b1);
        cycles(5);
        check("t5_addr0_released", a0, 1'b0);
        check("t5_no_byte", m_valid, 1'b0);
        cycles(20);
        check("t5_sticky", timeout_err, 1'b1);
        silent = 1'b0;
        cycles(20);
`else
        cycles(100);
        check("t5_timeout_tied", timeout_err, 1'b0);
`endif

        // Counter wrap from a preset value.
        @(posedge clk);
        #2;
        force dut.byte_count = 16'hFFFE;
        exp_count = 16'hFFFE;
        #1;
        release dut.byte_count;
        acc0 = accepted;
        fifo = 1'b1;
        wait_accepts(acc0 + 3, 600, "t6_accept3");
        fifo = 1'b0;
        cycles(60);
        check("t6_wrapped", byte_count, 16'h0001);

        // Reset while waiting for data.
        r0 = req_seen;
        fifo = 1'b1;
        wait_req(r0 + 1, 300, "t6_request");
        fifo = 1'b0;
        cycles(2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_m_valid", m_valid, 1'b0);
        check("t6_rst_web", web, 1'b0);
        check("t6_rst_addrb", addrb, 2'd2);
        check("t6_rst_timeout", timeout_err, 1'b0);
        cycles(40);
        exp_q.delete();
        rst_n = 1'b1;
        acc0 = accepted;
        fifo = 1'b1;
        wait_accepts(acc0 + 2, 600, "t6_resume");
        fifo = 1'b0;
        cycles(100);
        check("t6_count_after_rst", byte_count, 16'd2);
        check("end_drained", exp_q.size(), 0);
        check("web_rules", web_viol, 0);
        check("low_hold", hold_viol, 0);
        check("valid_deassert", deassert_viol, 0);
        check("req_gating", gate_viol, 0);
        check("data_stable", stall_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
